// File: rtl/umi2apb_pkg.sv
// Shared constants and types for the UMI-to-APB bridge family.
// Opcodes, error codes, FSM state enum and cmd field offsets.
package umi2apb_pkg;
  localparam logic [4:0] REQ_READ   = 5'h01;
  localparam logic [4:0] REQ_WRITE  = 5'h03;
  localparam logic [4:0] REQ_POSTED = 5'h05;
  localparam logic [4:0] RESP_READ  = 5'h02;
  localparam logic [4:0] RESP_WRITE = 5'h04;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_DEV = 2'b10;
  localparam logic [1:0] ERR_NET = 2'b11;

  localparam int OPC_LSB  = 0;
  localparam int SIZE_LSB = 5;
  localparam int LEN_LSB  = 8;
  localparam int QOS_LSB  = 16;
  localparam int PROT_LSB = 20;
  localparam int CPY_MSB  = 21;
  localparam int ERR_LSB  = 24;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;
endpackage

// File: rtl/umi2apb_decode.sv
// UMI cmd decode: opcode class, LEN, slave index and legality.
// Ports: cmd[15:0], dsthi (dstaddr above APB region) -> len, sel, is_read, is_posted, legal.
module umi2apb_decode
  import umi2apb_pkg::*;
#(
  parameter int RAW  = 32,
  parameter int AW   = 64,
  parameter int DW   = 256,
  parameter int RW   = 32,
  parameter int NSLV = 4,
  parameter int SW   = (NSLV > 1) ? $clog2(NSLV) : 1
) (
  input  logic [15:0]     cmd,
  input  logic [AW-RAW-1:0] dsthi,
  output logic [7:0]      len,
  output logic [SW-1:0]   sel,
  output logic            is_read,
  output logic            is_posted,
  output logic            legal
);
  localparam int HW = AW - RAW;
  localparam int NW = DW / RW;
  localparam logic [2:0] SZ = 3'($clog2(RW / 8));

  logic [4:0]    opc;
  logic [2:0]    size;
  logic          is_write;
  logic [HW-1:0] upper;

  assign opc       = cmd[OPC_LSB +: 5];
  assign size      = cmd[SIZE_LSB +: 3];
  assign len       = cmd[LEN_LSB +: 8];
  assign is_read   = opc == REQ_READ;
  assign is_write  = opc == REQ_WRITE;
  assign is_posted = opc == REQ_POSTED;

  assign sel   = SW'(dsthi & HW'(NSLV - 1));
  assign upper = dsthi >> $clog2(NSLV);

  assign legal = (is_read | is_write | is_posted)
               && (size == SZ)
               && (32'(len) < NW)
               && (upper == '0);
endmodule

// File: rtl/umi2apb_multi.sv
// UMI device port to NSLV APB requesters; multi-beat split, packed read response.
// Ports: udev_req_*/udev_resp_* UMI side, apb_* shared APB bus with per-slave psel/pready/prdata.
// Option: define UMI2APB_TIMEOUT_EN to abort stuck ACCESS after 0xFFFF cycles with NETERR.
module umi2apb_multi
  import umi2apb_pkg::*;
#(
  parameter int RAW  = 32,
  parameter int AW   = 64,
  parameter int CW   = 32,
  parameter int DW   = 256,
  parameter int RW   = 32,
  parameter int NSLV = 4
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic               udev_req_valid,
  output logic               udev_req_ready,
  input  logic [CW-1:0]      udev_req_cmd,
  input  logic [AW-1:0]      udev_req_dstaddr,
  input  logic [AW-1:0]      udev_req_srcaddr,
  input  logic [DW-1:0]      udev_req_data,
  output logic               udev_resp_valid,
  input  logic               udev_resp_ready,
  output logic [CW-1:0]      udev_resp_cmd,
  output logic [AW-1:0]      udev_resp_dstaddr,
  output logic [AW-1:0]      udev_resp_srcaddr,
  output logic [DW-1:0]      udev_resp_data,
  output logic [RAW-1:0]     apb_paddr,
  output logic [2:0]         apb_pprot,
  output logic [NSLV-1:0]    apb_psel,
  output logic               apb_penable,
  output logic               apb_pwrite,
  output logic [RW-1:0]      apb_pwdata,
  output logic [RW/8-1:0]    apb_pstrb,
  input  logic [NSLV-1:0]    apb_pready,
  input  logic [NSLV-1:0]    apb_pslverr,
  input  logic [NSLV*RW-1:0] apb_prdata
);
  localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;

  state_t          state, state_nx;
  logic [CPY_MSB:0] cmd_q;
  logic [AW-1:0]   dst_q, src_q;
  logic [DW-1:0]   wdat_q, rdat_q;
  logic [7:0]      beat_q;
  logic [1:0]      err_q;
  logic            gap_q;

  logic [15:0]       d_cmd;
  logic [AW-RAW-1:0] d_hi;
  logic [7:0]        d_len;
  logic [SW-1:0]     d_sel;
  logic              d_rd, d_po, d_legal;
  logic              accept, done, last, abort, active;
  logic              pready_s, pslverr_s;
  logic [RW-1:0]     prdata_s;

  // Decode the live request while idle, the latched one afterwards.
  assign d_cmd = (state == IDLE) ? udev_req_cmd[15:0] : cmd_q[15:0];
  assign d_hi  = (state == IDLE) ? udev_req_dstaddr[AW-1:RAW]
                                 : dst_q[AW-1:RAW];

  umi2apb_decode #(
    .RAW(RAW), .AW(AW), .DW(DW), .RW(RW), .NSLV(NSLV), .SW(SW)
  ) u_dec (
    .cmd(d_cmd), .dsthi(d_hi), .len(d_len), .sel(d_sel),
    .is_read(d_rd), .is_posted(d_po), .legal(d_legal)
  );

  assign pready_s  = apb_pready[d_sel];
  assign pslverr_s = apb_pslverr[d_sel];
  assign prdata_s  = apb_prdata[d_sel*RW +: RW];

  assign accept = udev_req_valid & udev_req_ready;
  assign done   = (state == ACCESS) & pready_s;
  assign last   = beat_q == d_len;

`ifdef UMI2APB_TIMEOUT_EN
  logic [15:0] tmo_q;
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) tmo_q <= '0;
    else if (state != ACCESS || pready_s) tmo_q <= '0;
    else tmo_q <= tmo_q + 16'd1;
  assign abort = (state == ACCESS) & ~pready_s & (tmo_q == 16'hFFFF);
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge nreset)
    if (!nreset) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (accept)
          state_nx = d_legal ? SETUP : (d_po ? IDLE : RESP);
      SETUP:
        if (!gap_q) state_nx = ACCESS;
      ACCESS:
        if (abort || (done && last)) state_nx = d_po ? IDLE : RESP;
        else if (done) state_nx = SETUP;
      RESP:
        if (udev_resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      cmd_q  <= '0;
      dst_q  <= '0;
      src_q  <= '0;
      wdat_q <= '0;
      rdat_q <= '0;
      beat_q <= '0;
      err_q  <= ERR_OK;
      gap_q  <= 1'b0;
    end else begin
      gap_q <= done & ~last;
      if (accept) begin
        cmd_q  <= udev_req_cmd[CPY_MSB:0];
        dst_q  <= udev_req_dstaddr;
        src_q  <= udev_req_srcaddr;
        wdat_q <= udev_req_data;
        rdat_q <= '0;
        beat_q <= '0;
        err_q  <= d_legal ? ERR_OK : ERR_DEV;
      end else if (done) begin
        if (d_rd) rdat_q[beat_q*RW +: RW] <= prdata_s;
        if (pslverr_s) err_q <= err_q | ERR_DEV;
        beat_q <= beat_q + 8'd1;
      end else if (abort) begin
        err_q <= ERR_NET;
      end
    end

  // A one-cycle gap after each beat keeps psel low between beats.
  assign active = ((state == SETUP) & ~gap_q) | (state == ACCESS);

  always_comb begin
    udev_req_ready    = state == IDLE;
    udev_resp_valid   = state == RESP;
    udev_resp_cmd     = '0;
    udev_resp_dstaddr = '0;
    udev_resp_srcaddr = '0;
    udev_resp_data    = '0;
    if (state == RESP) begin
      udev_resp_cmd[CPY_MSB:SIZE_LSB] = cmd_q[CPY_MSB:SIZE_LSB];
      udev_resp_cmd[OPC_LSB +: 5]     = d_rd ? RESP_READ : RESP_WRITE;
      udev_resp_cmd[ERR_LSB +: 2]     = err_q;
      udev_resp_dstaddr = src_q;
      udev_resp_srcaddr = dst_q;
      udev_resp_data    = rdat_q;
    end
  end

  always_comb begin
    apb_pprot   = 3'b000;
    apb_psel    = '0;
    apb_penable = 1'b0;
    apb_pwrite  = 1'b0;
    apb_paddr   = '0;
    apb_pwdata  = '0;
    apb_pstrb   = '0;
    if (active) begin
      apb_psel    = NSLV'(1) << d_sel;
      apb_penable = state == ACCESS;
      apb_pwrite  = ~d_rd;
      apb_paddr   = dst_q[RAW-1:0] + RAW'(beat_q * (RW / 8));
      apb_pwdata  = wdat_q[beat_q*RW +: RW];
      apb_pstrb   = '1;
    end
  end
endmodule

// File: doc/umi2apb_multi.md
Name: umi2apb_multi

Overview:
- Next-generation UMI-to-APB bridge: one UMI device port drives NSLV independent APB requester ports.
- Target slave is decoded from the dstaddr bits above the APB region.
- Multi-word UMI requests (LEN>0) are split into sequential APB beats, and read data is packed into one UMI response.
- Sits between the UMI fabric and clusters of APB register banks or SRAM-backed peripherals.

Parameters:
- RAW, 32, APB address width per slave
- AW, 64, UMI address width
- CW, 32, UMI command width
- DW, 256, UMI data width; must be a multiple of RW
- RW, 32, APB data width (32 or 64)
- NSLV, 4, number of APB slave ports (power of 2, 1..16)

Ports:
- clk  in  1  bridge and APB clock
- nreset  in  1  asynchronous active-low reset
- udev_req_valid/ready  in/out  1  UMI request handshake
- udev_req_cmd  in  CW  UMI request command
- udev_req_dstaddr, udev_req_srcaddr  in  AW  request addresses
- udev_req_data  in  DW  request data
- udev_resp_valid/ready  out/in  1  UMI response handshake
- udev_resp_cmd  out  CW  response command
- udev_resp_dstaddr, udev_resp_srcaddr  out  AW  response addresses
- udev_resp_data  out  DW  response data
- apb_paddr  out  RAW  shared address
- apb_pprot  out  3  shared protection, tied 3'b000
- apb_psel  out  NSLV  one-hot select
- apb_penable, apb_pwrite  out  1  shared
- apb_pwdata  out  RW  shared write data
- apb_pstrb  out  RW/8  shared strobes, all ones
- apb_pready, apb_pslverr  in  NSLV  per-slave
- apb_prdata  in  NSLV*RW  per-slave read data, slave i at [i*RW +: RW]

Behaviour:
- Reset: all outputs 0 except udev_req_ready; state IDLE; beat counter 0.
- udev_req_ready = (state==IDLE). A request is accepted on valid&ready and all request fields are latched.
- Decode:
  - opcode = cmd[4:0]: READ 0x01, WRITE 0x03, POSTED 0x05; other opcodes are illegal.
  - SIZE = cmd[7:5]; LEN = cmd[15:8]; sel = dstaddr[RAW +: log2(NSLV)].
- Error check: if illegal opcode, or SIZE != log2(RW/8), or LEN+1 > DW/RW, or dstaddr[AW-1:RAW+log2(NSLV)] != 0, go straight to RESP with ERR=DEVERR. No APB access is made. POSTED errors are dropped silently and return to IDLE.
- FSM:
  - IDLE -> SETUP on accept.
  - SETUP (psel[sel]=1, penable=0, one cycle) -> ACCESS.
  - ACCESS (penable=1): wait for pready[sel].
  - On pready: capture prdata into data word[beat], OR pslverr into a sticky err flag, then beat++.
  - If beat==LEN go to RESP (POSTED: IDLE); else go to SETUP for the next beat. psel stays high only if the spec permits; here it drops for one cycle, strict APB.
  - RESP: resp_valid=1 until resp_ready, then IDLE.
- Beat b: paddr = dstaddr[RAW-1:0] + b*(RW/8), wrapping modulo 2^RAW; pwdata = req_data[b*RW +: RW]; pwrite=1 for WRITE/POSTED.
- Response:
  - cmd: opcode RESP_READ 0x02 or RESP_WRITE 0x04; SIZE/LEN/QOS/PROT copied from the request; cmd[25:24] = 2'b10 if any beat errored, else 2'b00.
  - dstaddr = req srcaddr; srcaddr = req dstaddr.
  - data: read words packed, unused words 0; for writes data is 0.
- Latency, single-beat read with immediate pready: accept at cycle 0, SETUP 1, ACCESS 2, resp_valid at cycle 3.
- Back-pressure: resp_valid held with stable fields; no new request is accepted until the response is taken.
- All slaves deselected except sel. Responses from unselected slaves are ignored.
- An asynchronous nreset mid-transfer aborts immediately. The pending response is lost and psel/penable go low.

Optional Feature:
- Macro: UMI2APB_TIMEOUT_EN.
- Enabled: a 16-bit counter runs in ACCESS and is cleared on each beat. When it reaches 0xFFFF the transfer is aborted: psel/penable are deasserted, err=2'b11 (NETERR) is set, and the FSM goes to RESP (POSTED: IDLE) with remaining beats skipped.
- Disabled: ACCESS waits indefinitely for pready. The counter logic is absent.

Decomposition:
- Package umi2apb_pkg holds:
  - the opcode localparams (REQ_READ/WRITE/POSTED, RESP_READ/WRITE);
  - the ERR codes (OK, DEVERR, NETERR);
  - the FSM state enum {IDLE, SETUP, ACCESS, RESP};
  - cmd field offset constants.
- Sub-module: umi2apb_decode, a combinational block for cmd field extraction, legality check and slave index, reused by future AXI-Lite bridges.

Test Plan:
- Read at dstaddr 0x1_0000_0010 (slave 1), LEN=0, SIZE=2 -> psel=4'b0010, paddr=0x10, resp opcode 0x02, data[31:0] = the slave's word, ERR=0.
- Write LEN=3 at slave 2, addr 0x20, data words A,B,C,D -> four APB beats at 0x20/24/28/2C with A..D; one RESP_WRITE.
- Read LEN=1 where slave asserts pslverr on beat 0 only -> both beats run, resp ERR=2'b10, data word1 valid.
- Illegal cases: SIZE=0, or LEN=8 with DW=256, or upper dstaddr bit 40 set -> no psel activity, DEVERR response; the POSTED variant yields no response.
- Randomised pready, with resp_ready held low 20 cycles -> resp fields stable, req_ready=0 throughout; read-back matches writes via a la_spram-backed slave.
- With UMI2APB_TIMEOUT_EN and pready tied 0 -> after 65535 ACCESS cycles psel drops and the response carries ERR=2'b11.
